// File: rtl/mos6502_pkg.sv
// Shared definitions for the 6502 ALU slice.
//   alu_op_e     : internal operation code after select-priority resolution
//   BCD_*        : decimal-adjust constants and nibble limit
//   op_select()  : collapses the seven (nominally one-hot) selects into one
//                  operation, resolving overlaps by fixed priority
package mos6502_pkg;

    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_SUM  = 3'd1,
        OP_SUB  = 3'd2,
        OP_AND  = 3'd3,
        OP_EOR  = 3'd4,
        OP_OR   = 3'd5,
        OP_SHR  = 3'd6,
        OP_SHCR = 3'd7
    } alu_op_e;

    localparam logic [7:0] BCD_LO_ADJ  = 8'h06;
    localparam logic [7:0] BCD_HI_ADJ  = 8'h60;
    localparam logic [3:0] BCD_NIB_MAX = 4'd9;

    function automatic alu_op_e op_select(
        input logic sums,
        input logic subs,
        input logic ands,
        input logic eors,
        input logic ors,
        input logic shftr,
        input logic shftcr
    );
        alu_op_e op;
        if (sums)        op = OP_SUM;
        else if (subs)   op = OP_SUB;
        else if (ands)   op = OP_AND;
        else if (eors)   op = OP_EOR;
        else if (ors)    op = OP_OR;
        else if (shftr)  op = OP_SHR;
        else if (shftcr) op = OP_SHCR;
        else             op = OP_NONE;
        return op;
    endfunction

endpackage

// File: rtl/mos6502_alu_bcd_adjust.sv
// Decimal correction of the binary adder result.
//   bin_i       : 8-bit binary sum (A+B+C) or difference (A+~B+C)
//   lo_carry_i  : carry out of the low nibble of the binary adder
//   hi_carry_i  : carry out of bit 7 of the binary adder
//   dec_add_i   : apply BCD addition correction
//   dec_sub_i   : apply BCD subtraction correction
//   res_o       : corrected result (bin_i when neither mode is set)
//   carry_o     : decimal carry / no-borrow (hi_carry_i when no mode set)
module bcd_adjust
    import mos6502_pkg::*;
(
    input  logic [7:0] bin_i,
    input  logic       lo_carry_i,
    input  logic       hi_carry_i,
    input  logic       dec_add_i,
    input  logic       dec_sub_i,
    output logic [7:0] res_o,
    output logic       carry_o
);

    logic       lo_fix;
    logic       hi_fix;
    logic [8:0] lo_fixed;

    always_comb begin
        lo_fix   = 1'b0;
        hi_fix   = 1'b0;
        lo_fixed = {1'b0, bin_i};
        res_o    = bin_i;
        carry_o  = hi_carry_i;
        if (dec_add_i) begin
            lo_fix   = lo_carry_i || (bin_i[3:0] > BCD_NIB_MAX);
            lo_fixed = {1'b0, bin_i} + (lo_fix ? {1'b0, BCD_LO_ADJ} : 9'd0);
            // The low-nibble fix can ripple into (and out of) the high
            // nibble, so the high decision looks at the already-fixed value.
            hi_fix   = hi_carry_i || lo_fixed[8] || (lo_fixed[7:4] > BCD_NIB_MAX);
            res_o    = lo_fixed[7:0] + (hi_fix ? BCD_HI_ADJ : 8'h00);
            carry_o  = hi_fix;
        end else if (dec_sub_i) begin
            // A missing carry out of a nibble in A+~B+C is a borrow.
            res_o   = bin_i - (lo_carry_i ? 8'h00 : BCD_LO_ADJ)
                            - (hi_carry_i ? 8'h00 : BCD_HI_ADJ);
            carry_o = hi_carry_i;
        end
    end

endmodule

// File: rtl/mos6502_alu.sv
// 6502 ALU with hold register and tri-state bus drivers.
//   clk, clr                : clock, async active-high clear
//   a_in, b_in, cin         : operands and carry in (not latched here)
//   sums..shftcr            : operation selects, priority sums > .. > shftcr
//   dec_en                  : BCD mode for sums/subs
//   aluadloa/alusboa/aludbwa: enables driving the hold register onto adl/sb/db
//   db, adl, sb             : tri-state buses
//   cout, zero, overflow, neg : registered flags
module mos6502_alu
    import mos6502_pkg::*;
(
    input  logic       clk,
    input  logic       clr,
    input  logic [7:0] a_in,
    input  logic [7:0] b_in,
    input  logic       cin,
    input  logic       sums,
    input  logic       subs,
    input  logic       ands,
    input  logic       eors,
    input  logic       ors,
    input  logic       shftr,
    input  logic       shftcr,
    input  logic       dec_en,
    input  logic       aluadloa,
    input  logic       alusboa,
    input  logic       aludbwa,
    output wire  [7:0] db,
    output wire  [7:0] adl,
    output wire  [7:0] sb,
    output logic       cout,
    output logic       zero,
    output logic       overflow,
    output logic       neg
);

    alu_op_e    op;
    logic [7:0] b_op;
    logic [4:0] lo_sum;
    logic [8:0] bin_sum;
    logic       add_ovf;
    logic [7:0] bcd_res;
    logic       bcd_carry;

    logic [7:0] hold_d, hold_q;
    logic       cout_d, cout_q;
    logic       ovf_d,  ovf_q;
    logic       zero_q, neg_q;

    assign op   = op_select(sums, subs, ands, eors, ors, shftr, shftcr);
    // Subtraction reuses the adder with B inverted; cin=1 means no borrow.
    assign b_op = (op == OP_SUB) ? ~b_in : b_in;

    assign lo_sum  = {1'b0, a_in[3:0]} + {1'b0, b_op[3:0]} + {4'd0, cin};
    assign bin_sum = {1'b0, a_in} + {1'b0, b_op} + {8'd0, cin};
    // With B inverted for subtract this one test covers both add and sub rules.
    assign add_ovf = (a_in[7] == b_op[7]) && (bin_sum[7] != a_in[7]);

    bcd_adjust u_bcd_adjust (
        .bin_i      (bin_sum[7:0]),
        .lo_carry_i (lo_sum[4]),
        .hi_carry_i (bin_sum[8]),
        .dec_add_i  (dec_en && (op == OP_SUM)),
        .dec_sub_i  (dec_en && (op == OP_SUB)),
        .res_o      (bcd_res),
        .carry_o    (bcd_carry)
    );

    always_comb begin
        hold_d = hold_q;
        cout_d = cout_q;
        ovf_d  = ovf_q;
        case (op)
            OP_SUM, OP_SUB: begin
                hold_d = bcd_res;
                cout_d = bcd_carry;
                ovf_d  = add_ovf;
            end
            OP_AND: begin
                hold_d = a_in & b_in;
                cout_d = 1'b0;
                ovf_d  = 1'b0;
            end
            OP_EOR: begin
                hold_d = a_in ^ b_in;
                cout_d = 1'b0;
                ovf_d  = 1'b0;
            end
            OP_OR: begin
                hold_d = a_in | b_in;
                cout_d = 1'b0;
                ovf_d  = 1'b0;
            end
            OP_SHR: begin
                hold_d = {1'b0, a_in[7:1]};
                cout_d = a_in[0];
                ovf_d  = 1'b0;
            end
            OP_SHCR: begin
                hold_d = {cin, a_in[7:1]};
                cout_d = a_in[0];
                ovf_d  = 1'b0;
            end
            default: begin
                hold_d = hold_q;
                cout_d = cout_q;
                ovf_d  = ovf_q;
            end
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            hold_q <= 8'h00;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
        end else if (op != OP_NONE) begin
            hold_q <= hold_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
            zero_q <= (hold_d == 8'h00);
            neg_q  <= hold_d[7];
        end
    end

    assign cout     = cout_q;
    assign zero     = zero_q;
    assign overflow = ovf_q;
    assign neg      = neg_q;

    assign db  = aludbwa  ? hold_q : 8'hzz;
    assign adl = aluadloa ? hold_q : 8'hzz;
    assign sb  = alusboa  ? hold_q : 8'hzz;

endmodule

// File: tb/tb_mos6502_alu.sv
// Scoreboard bench for mos6502_alu: stimulus pushes expected state, a monitor
// pops and compares one clock later; buses and async clear checked directly.
module tb_mos6502_alu;

    typedef struct {
        logic [7:0] r;
        logic       c;
        logic       z;
        logic       v;
        logic       n;
    } exp_t;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic [7:0] a_in = 8'h00;
    logic [7:0] b_in = 8'h00;
    logic       cin = 1'b0;
    logic [6:0] sel_v = 7'd0;
    logic       dec_en = 1'b0;
    logic       aluadloa = 1'b0;
    logic       alusboa = 1'b0;
    logic       aludbwa = 1'b1;
    wire  [7:0] db, adl, sb;
    logic       cout, zero, overflow, neg;

    // Bench-side drivers used to prove a bus is released (high-Z).
    logic [7:0] pv = 8'h00;
    logic       pdb = 1'b0, padl = 1'b0, psb = 1'b0;
    assign db  = pdb  ? pv : 8'hzz;
    assign adl = padl ? pv : 8'hzz;
    assign sb  = psb  ? pv : 8'hzz;

    int   tests = 0;
    int   fails = 0;
    exp_t q[$];
    exp_t mstate;

    localparam logic [6:0] S_SUM = 7'b0000001, S_SUB = 7'b0000010, S_AND = 7'b0000100,
                           S_EOR = 7'b0001000, S_OR  = 7'b0010000, S_SHR = 7'b0100000,
                           S_SHCR = 7'b1000000;

    mos6502_alu dut (
        .clk(clk), .clr(clr), .a_in(a_in), .b_in(b_in), .cin(cin),
        .sums(sel_v[0]), .subs(sel_v[1]), .ands(sel_v[2]), .eors(sel_v[3]),
        .ors(sel_v[4]), .shftr(sel_v[5]), .shftcr(sel_v[6]), .dec_en(dec_en),
        .aluadloa(aluadloa), .alusboa(alusboa), .aludbwa(aludbwa),
        .db(db), .adl(adl), .sb(sb),
        .cout(cout), .zero(zero), .overflow(overflow), .neg(neg)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %02h, expected %02h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int sgn(input logic [7:0] x);
        int v;
        v = int'(x);
        return (v >= 128) ? v - 256 : v;
    endfunction

    function automatic int bcd2int(input logic [7:0] x);
        return int'(x[7:4]) * 10 + int'(x[3:0]);
    endfunction

    function automatic logic [7:0] int2bcd(input int n);
        logic [3:0] t, u;
        t = 4'((n / 10) % 10);
        u = 4'(n % 10);
        return {t, u};
    endfunction

    // Reference: decimal arithmetic on the values the BCD digits represent,
    // plain integer arithmetic for binary, signed range test for overflow.
    function automatic exp_t ref_model(input logic [7:0] a, input logic [7:0] b, input logic ci,
                                       input logic [6:0] sel, input logic dec, input exp_t prev);
        exp_t e;
        int   op, s, ci_i;
        logic found;
        e = prev;
        op = -1;
        found = 1'b0;
        ci_i = ci ? 1 : 0;
        for (int i = 0; i < 7; i++)
            if (sel[i] && !found) begin op = i; found = 1'b1; end
        if (!found) return prev;
        e.v = 1'b0;
        case (op)
            0: begin
                s   = sgn(a) + sgn(b) + ci_i;
                e.v = (s > 127) || (s < -128);
                if (dec) begin
                    s = bcd2int(a) + bcd2int(b) + ci_i;
                    e.c = (s > 99);
                    e.r = int2bcd(s % 100);
                end else begin
                    s = int'(a) + int'(b) + ci_i;
                    e.c = (s > 255);
                    e.r = 8'(s % 256);
                end
            end
            1: begin
                s   = sgn(a) - sgn(b) - (1 - ci_i);
                e.v = (s > 127) || (s < -128);
                if (dec) begin
                    s = bcd2int(a) - bcd2int(b) - (1 - ci_i);
                    e.c = (s >= 0);
                    e.r = int2bcd((s + 100) % 100);
                end else begin
                    s = int'(a) - int'(b) - (1 - ci_i);
                    e.c = (s >= 0);
                    e.r = 8'((s + 256) % 256);
                end
            end
            2: begin e.r = a & b; e.c = 1'b0; end
            3: begin e.r = a ^ b; e.c = 1'b0; end
            4: begin e.r = a | b; e.c = 1'b0; end
            5: begin e.r = 8'(int'(a) / 2);                   e.c = a[0]; end
            default: begin e.r = 8'(int'(a) / 2 + 128 * ci_i); e.c = a[0]; end
        endcase
        e.z = (e.r == 8'h00);
        e.n = e.r[7];
        return e;
    endfunction

    task automatic do_cycle(input logic [7:0] a, input logic [7:0] b, input logic ci,
                            input logic [6:0] sel, input logic dec);
        @(negedge clk);
        a_in = a; b_in = b; cin = ci; sel_v = sel; dec_en = dec;
        mstate = ref_model(a, b, ci, sel, dec, mstate);
        q.push_back(mstate);
        @(posedge clk);
        #2 sel_v = 7'd0;
    endtask

    task automatic check_flags_now(input string tag, input exp_t e);
        check({tag, ".R"}, db, e.r);
        check({tag, ".C"}, {7'd0, cout}, {7'd0, e.c});
        check({tag, ".Z"}, {7'd0, zero}, {7'd0, e.z});
        check({tag, ".V"}, {7'd0, overflow}, {7'd0, e.v});
        check({tag, ".N"}, {7'd0, neg}, {7'd0, e.n});
    endtask

    // Monitor: whenever an expectation is pending, compare right after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check_flags_now("sb", e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t zero_e;
        int   r;
        logic [6:0] sel;
        logic       dec;
        logic [7:0] a, b;
        zero_e = '{r: 8'h00, c: 1'b0, z: 1'b0, v: 1'b0, n: 1'b0};
        mstate = zero_e;

        #2 check_flags_now("reset", zero_e);
        @(negedge clk);
        clr = 1'b0;

        // Directed vectors
        do_cycle(8'h50, 8'h50, 1'b0, S_SUM, 1'b0);
        do_cycle(8'hFF, 8'h01, 1'b0, S_SUM, 1'b0);
        do_cycle(8'h05, 8'h03, 1'b1, S_SUB, 1'b0);
        do_cycle(8'h19, 8'h28, 1'b0, S_SUM, 1'b1);
        do_cycle(8'h99, 8'h01, 1'b0, S_SUM, 1'b1);
        do_cycle(8'h42, 8'h13, 1'b1, S_SUB, 1'b1);
        do_cycle(8'h01, 8'h00, 1'b1, S_SHCR, 1'b0);
        do_cycle(8'h81, 8'h00, 1'b1, S_SHR, 1'b0);
        do_cycle(8'h00, 8'h00, 1'b0, 7'd0, 1'b0);          // no select: retain
        do_cycle(8'h0F, 8'hF0, 1'b0, S_SUM | S_OR, 1'b0);  // overlap: sum wins
        do_cycle(8'h3C, 8'h0F, 1'b1, S_AND | S_SHR, 1'b0);
        do_cycle(8'h3C, 8'h0F, 1'b1, S_EOR | S_SHCR, 1'b0);
        do_cycle(8'h5A, 8'h00, 1'b0, S_OR, 1'b0);

        // Bus enables with hold = 0x5A
        @(negedge clk);
        aludbwa = 1'b0; alusboa = 1'b1; aluadloa = 1'b0;
        pv = 8'hC3; pdb = 1'b1; padl = 1'b1;
        #1 check("bus.sb_only.sb", sb, 8'h5A);
        check("bus.sb_only.db", db, 8'hC3);
        check("bus.sb_only.adl", adl, 8'hC3);
        pv = 8'h3C;
        #1 check("bus.sb_only.db2", db, 8'h3C);
        check("bus.sb_only.adl2", adl, 8'h3C);
        pdb = 1'b0; padl = 1'b0;
        aludbwa = 1'b1; alusboa = 1'b1; aluadloa = 1'b1;
        #1 check("bus.all.db", db, 8'h5A);
        check("bus.all.adl", adl, 8'h5A);
        check("bus.all.sb", sb, 8'h5A);
        aludbwa = 1'b0; alusboa = 1'b0; aluadloa = 1'b0;
        pv = 8'hA5; pdb = 1'b1; padl = 1'b1; psb = 1'b1;
        #1 check("bus.none.db", db, 8'hA5);
        check("bus.none.adl", adl, 8'hA5);
        check("bus.none.sb", sb, 8'hA5);
        pdb = 1'b0; padl = 1'b0; psb = 1'b0;
        aludbwa = 1'b1;

        // Async clear pulsed between edges after a result is held
        do_cycle(8'h50, 8'h50, 1'b0, S_SUM, 1'b0);
        @(negedge clk);
        #1 check_flags_now("pre_clr", mstate);
        #1 clr = 1'b1;
        #1 check_flags_now("clr_pulse", zero_e);
        clr = 1'b0;
        mstate = zero_e;
        do_cycle(8'h00, 8'h00, 1'b0, 7'd0, 1'b0);

        // Select held across an edge while clr is high: no update
        do_cycle(8'hA5, 8'h00, 1'b0, S_OR, 1'b0);
        @(negedge clk);
        clr = 1'b1;
        a_in = 8'h01; b_in = 8'h01; cin = 1'b0; sel_v = S_SUM; dec_en = 1'b0;
        mstate = zero_e;
        q.push_back(zero_e);
        @(posedge clk);
        #2;
        @(negedge clk);
        clr = 1'b0;
        sel_v = 7'd0;
        do_cycle(8'h01, 8'h01, 1'b0, S_SUM, 1'b0);         // first update after clear

        // Randomized
        for (int it = 0; it < 400; it++) begin
            r = $urandom_range(0, 9);
            if (r <= 6)      sel = 7'(1 << r);
            else if (r == 7) sel = 7'd0;
            else             sel = 7'($urandom);
            dec = 1'($urandom_range(0, 1));
            if (dec) begin
                a = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
                b = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            end else begin
                a = 8'($urandom);
                b = 8'($urandom);
            end
            do_cycle(a, b, 1'($urandom_range(0, 1)), sel, dec);
            if (it % 16 == 0) begin
                #1 aluadloa = 1'b1; alusboa = 1'b1;
                #1 check("rnd.adl", adl, mstate.r);
                check("rnd.sb", sb, mstate.r);
                aluadloa = 1'b0; alusboa = 1'b0;
            end
        end

        for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
        #2;
        if (q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d expectations pending, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mos6502_alu.md
MOS6502_ALU -- requirements
Module: mos6502_alu

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset, named clk and clr.
REQ-002 clk  input  1  rising-edge clock; all state updates on it.
REQ-003 clr  input  1  async active-high reset.
REQ-004 a_in  input  8  operand A, from pre-ALU A latch.
REQ-005 b_in  input  8  operand B, from pre-ALU B latch.
REQ-006 cin  input  1  carry in.
REQ-007 sums, subs, ands, eors, ors, shftr, shftcr  input  1 each  operation selects, intended one-hot.
REQ-008 dec_en  input  1  BCD mode; applies to sums/subs only.
REQ-009 aluadloa, alusboa, aludbwa  input  1 each  output enables onto the adl, sb and db buses.
REQ-010 db, adl, sb  output (tri-state)  8 each  shared buses; drive the hold register when enabled, else high-Z.
REQ-011 cout, zero, overflow, neg  output  1 each  registered flags.

Function
REQ-012 SHALL register the result and all four flags on each rising clk when at least one select is high.
REQ-013 With no select high, the hold register and flags SHALL retain their values.
REQ-014 Select priority on overlap SHALL be: sums > subs > ands > eors > ors > shftr > shftcr.
REQ-015 sums: R = A + B + cin (9-bit); cout = bit 8.
REQ-016 sums: overflow = (A7 == B7) and (R7 != A7).
REQ-017 subs: R = A + ~B + cin, so cin=1 means no borrow; cout = bit 8 (1 = no borrow).
REQ-018 subs: overflow = (A7 != B7) and (R7 != A7).
REQ-019 ands/eors/ors: R = A&B, A^B, A|B; cout = 0, overflow = 0.
REQ-020 shftr: R = {0, A[7:1]}; cout = A0; overflow = 0.
REQ-021 shftcr: R = {cin, A[7:1]}; cout = A0; overflow = 0.
REQ-022 dec_en with sums: per-nibble BCD add.
- Low nibble > 9 or nibble carry: add 6.
- High nibble likewise: add 0x60.
- cout = decimal carry; overflow from the binary add.
REQ-023 dec_en with subs: BCD subtract.
- Subtract 6 from a nibble that borrowed.
- cout = no-borrow; overflow from the binary subtract.
REQ-024 zero = (R == 0) and neg = R7, both from the final (post-BCD-correction) result.
REQ-025 Flags SHALL be registered in the same cycle as R; latency is 1 clock from operand and select setup to the registered value.
REQ-026 Bus drive SHALL be combinational from the hold register and the enables.
REQ-027 Several enables may be active at once and each bus is driven independently.
REQ-028 Operand inputs are not latched inside this block.

Reset
REQ-029 While clr is high, the hold register, cout, zero, overflow and neg SHALL be 0, asynchronously.
REQ-030 A clr asserted mid-operation SHALL discard the pending result.
REQ-031 The first update after clr deasserts SHALL occur on the next rising clk with a select high.
REQ-032 Bus outputs SHALL depend only on the enables, never on clr.

Structure
REQ-033 The operation-select encoding, the BCD constants 0x06/0x60 and the nibble limit 9 SHALL live in a shared package, mos6502_pkg.
REQ-034 BCD adjust SHALL be one sub-module, bcd_adjust: inputs binary sum/difference, nibble carries and mode; outputs corrected R and carry.
REQ-035 Tri-state drivers SHALL be inline continuous assignments.

Verification
REQ-036 sums, A=0x50, B=0x50, cin=0 -> R=0xA0, cout=0, V=1, N=1, Z=0.
REQ-037 sums, A=0xFF, B=0x01, cin=0 -> R=0x00, cout=1, Z=1, V=0; then subs, A=0x05, B=0x03, cin=1 -> R=0x02, cout=1.
REQ-038 dec_en sums, A=0x19, B=0x28, cin=0 -> 0x47, cout=0; A=0x99, B=0x01 -> 0x00, cout=1, Z=1; dec_en subs, A=0x42, B=0x13, cin=1 -> 0x29, cout=1.
REQ-039 shftcr, A=0x01, cin=1 -> R=0x80, cout=1, N=1; shftr, A=0x81 -> R=0x40, cout=1.
REQ-040 Buses with R=0x5A: alusboa only -> sb=0x5A, db/adl high-Z; all three enables -> all buses 0x5A; no enables -> all high-Z.
REQ-041 Reset: clr pulsed between clk edges after a result is held -> R and flags 0 immediately; a select pulse held through the reset does not update state.
